// File: rtl/apb_user_registers.sv
// rtl/apb_user_registers.sv - 16550-style UART user register file behind an APB slave
// Optional feature macro: SCRATCH_REG_EN (implements the addr-7 scratch register)
module apb_user_registers (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [2:0]  PADDR,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA
);

  logic [7:0] hold_q;
  logic [7:0] dll_q;
  logic [7:0] dlm_q;
  logic [7:0] lcr_q;
  logic [3:0] ier_q;
  logic       fcr_en_q;
  logic [1:0] fcr_trig_q;
  logic [4:0] mcr_q;
  logic       dr_q;
`ifdef SCRATCH_REG_EN
  logic [7:0] scr_q;
`endif

  logic       dlab;
  logic       wr_commit;
  logic       rd_setup;
  logic       rd_access;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [3:0] iir_id;
  logic       unused_bits;

  assign dlab      = lcr_q[7];
  assign wr_commit = PSELx & PENABLE & PWRITE;
  assign rd_setup  = PSELx & ~PENABLE & ~PWRITE;
  assign rd_access = PSELx & PENABLE & ~PWRITE;
  assign wdata     = PWDATA[7:0];
  assign iir_id    = (ier_q[0] & dr_q) ? 4'b0100 : 4'b0001;

  // Trigger level is held for the future UART core; nothing in this block reads it yet.
  assign unused_bits = &{1'b0, PWDATA[31:8], fcr_trig_q};

  always_comb begin
    rdata = 8'h00;
    case (PADDR)
      3'd0: rdata = dlab ? dll_q : hold_q;
      3'd1: rdata = dlab ? dlm_q : {4'b0000, ier_q};
      3'd2: rdata = {fcr_en_q, fcr_en_q, 2'b00, iir_id};
      3'd3: rdata = lcr_q;
      3'd4: rdata = {3'b000, mcr_q};
      3'd5: rdata = {1'b0, 1'b1, 1'b1, 4'b0000, dr_q};
      3'd6: rdata = 8'h00;
`ifdef SCRATCH_REG_EN
      3'd7: rdata = scr_q;
`else
      3'd7: rdata = 8'h00;
`endif
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      hold_q     <= 8'h00;
      dll_q      <= 8'h00;
      dlm_q      <= 8'h00;
      lcr_q      <= 8'h00;
      ier_q      <= 4'h0;
      fcr_en_q   <= 1'b0;
      fcr_trig_q <= 2'b00;
      mcr_q      <= 5'h00;
      dr_q       <= 1'b0;
`ifdef SCRATCH_REG_EN
      scr_q      <= 8'h00;
`endif
      PRDATA     <= 32'h0;
    end else begin
      if (wr_commit) begin
        case (PADDR)
          3'd0: begin
            if (dlab) begin
              dll_q <= wdata;
            end else begin
              hold_q <= wdata;
              dr_q   <= 1'b1;
            end
          end
          3'd1: begin
            if (dlab) dlm_q <= wdata;
            else      ier_q <= wdata[3:0];
          end
          3'd2: begin
            fcr_en_q   <= wdata[0];
            fcr_trig_q <= wdata[7:6];
          end
          3'd3: lcr_q <= wdata;
          3'd4: mcr_q <= wdata[4:0];
`ifdef SCRATCH_REG_EN
          3'd7: scr_q <= wdata;
`endif
          default: ;
        endcase
      end
      if (rd_setup) PRDATA <= {24'h0, rdata};
      // Draining the holding byte happens at the access edge, after PRDATA captured it.
      if (rd_access && (PADDR == 3'd0) && !dlab) dr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_user_registers.sv
// tb/tb_apb_user_registers.sv - randomized self-checking bench for apb_user_registers
module tb_apb_user_registers;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic [2:0]  PADDR = 3'd0;
  logic        PSELx = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;

  int vectors = 0;
  int errors = 0;

  apb_user_registers dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: the architectural registers of a 16550 as software sees them
  logic [7:0] m_hold, m_dll, m_dlm, m_lcr, m_scr;
  logic [3:0] m_ier;
  logic [4:0] m_mcr;
  logic       m_fifo, m_dr;

  function automatic void model_reset();
    m_hold = 0; m_dll = 0; m_dlm = 0; m_lcr = 0; m_scr = 0;
    m_ier = 0; m_mcr = 0; m_fifo = 0; m_dr = 0;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [7:0] d);
    case (a)
      0: if (m_lcr[7]) m_dll = d; else begin m_hold = d; m_dr = 1; end
      1: if (m_lcr[7]) m_dlm = d; else m_ier = d[3:0];
      2: m_fifo = d[0];
      3: m_lcr = d;
      4: m_mcr = d[4:0];
`ifdef SCRATCH_REG_EN
      7: m_scr = d;
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [7:0] v;
    case (a)
      0: v = m_lcr[7] ? m_dll : m_hold;
      1: v = m_lcr[7] ? m_dlm : 8'(m_ier);
      2: v = (m_fifo ? 8'hC0 : 8'h00) + ((m_ier[0] && m_dr) ? 8'h04 : 8'h01);
      3: v = m_lcr;
      4: v = 8'(m_mcr);
      5: v = 8'h60 + 8'(m_dr);
      6: v = 8'h00;
      default: v = m_scr;
    endcase
    return {24'h0, v};
  endfunction

  function automatic void model_after_read(input logic [2:0] a);
    if (a == 0 && !m_lcr[7]) m_dr = 0;
  endfunction

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge PCLK); #1;
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = {$urandom_range(0, 16777215), d};
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PSELx = 0; PENABLE = 0; PWRITE = 0;
    model_write(a, d);
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSELx = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #1 d = PRDATA;
    @(posedge PCLK); #1;
    PSELx = 0; PENABLE = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h60, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      apb_read(3'(i), d);
      vectors++;
      if (d !== {24'h0, exp_tab[i]}) begin
        errors++;
        $display("FAIL reset_default addr=%0d got=%h exp=%h", i, d, exp_tab[i]);
      end
    end
  endtask

  task automatic test_ier_mask();
    logic [31:0] d;
    apb_write(3, 8'h03);
    apb_write(1, 8'hFF);
    apb_read(1, d);
    vectors++;
    if (d !== 32'h0000000F) begin errors++; $display("FAIL ier_mask got=%h exp=0000000f", d); end
  endtask

  task automatic test_dlab();
    logic [31:0] d;
    apb_write(3, 8'hAA);
    apb_read(3, d);
    vectors++;
    if (d !== 32'h000000AA) begin errors++; $display("FAIL lcr_rw got=%h exp=000000aa", d); end
    apb_write(1, 8'hFF);
    apb_read(1, d);
    vectors++;
    if (d !== 32'h000000FF) begin errors++; $display("FAIL dlm_rw got=%h exp=000000ff", d); end
    apb_write(0, 8'h37);
    apb_read(0, d);
    vectors++;
    if (d !== 32'h00000037) begin errors++; $display("FAIL dll_rw got=%h exp=00000037", d); end
    apb_write(3, 8'h03);
    apb_read(1, d);
    vectors++;
    if (d !== 32'h0000000F) begin errors++; $display("FAIL ier_untouched got=%h exp=0000000f", d); end
    apb_read(5, d);
    vectors++;
    if (d !== 32'h00000060) begin errors++; $display("FAIL dll_no_dr got=%h exp=00000060", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    apb_write(1, 8'h01);
    apb_write(0, 8'h5A);
    apb_read(5, d);
    vectors++;
    if (d !== 32'h61) begin errors++; $display("FAIL lsr_dr_set got=%h exp=00000061", d); end
    apb_read(2, d);
    vectors++;
    if (d !== 32'h04) begin errors++; $display("FAIL iir_rda got=%h exp=00000004", d); end
    apb_read(0, d);
    model_after_read(0);
    vectors++;
    if (d !== 32'h5A) begin errors++; $display("FAIL rbr_data got=%h exp=0000005a", d); end
    apb_read(5, d);
    vectors++;
    if (d !== 32'h60) begin errors++; $display("FAIL lsr_dr_clear got=%h exp=00000060", d); end
    apb_read(2, d);
    vectors++;
    if (d !== 32'h01) begin errors++; $display("FAIL iir_none got=%h exp=00000001", d); end
  endtask

  task automatic test_fcr_ro();
    logic [31:0] d;
    apb_write(2, 8'hC1);
    apb_read(2, d);
    vectors++;
    if (d !== 32'hC1) begin errors++; $display("FAIL iir_fifo got=%h exp=000000c1", d); end
    apb_write(5, 8'hFF);
    apb_write(6, 8'hFF);
    apb_read(5, d);
    vectors++;
    if (d !== 32'h60) begin errors++; $display("FAIL lsr_ro got=%h exp=00000060", d); end
    apb_read(6, d);
    vectors++;
    if (d !== 32'h00) begin errors++; $display("FAIL msr_ro got=%h exp=00000000", d); end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic [31:0] e;
`ifdef SCRATCH_REG_EN
    e = 32'h3C;
`else
    e = 32'h00;
`endif
    apb_write(7, 8'h3C);
    apb_read(7, d);
    vectors++;
    if (d !== e) begin errors++; $display("FAIL scratch got=%h exp=%h", d, e); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] e;
    logic [2:0] a;
    logic [7:0] w;
    for (int n = 0; n < 400; n++) begin
      a = 3'($urandom_range(0, 7));
      w = 8'($urandom);
      if (a == 3 && $urandom_range(0, 1) == 1) w[7] = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        // Stray PENABLE/PWRITE without PSELx must leave everything untouched
        @(posedge PCLK); #1;
        PSELx = 0; PENABLE = 1; PWRITE = 1; PADDR = a; PWDATA = 32'($urandom);
        @(posedge PCLK); #1;
        PENABLE = 0; PWRITE = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        apb_write(a, w);
      end else begin
        e = model_read(a);
        apb_read(a, d);
        model_after_read(a);
        vectors++;
        if (d !== e) begin errors++; $display("FAIL random_read n=%0d addr=%0d got=%h exp=%h", n, a, d, e); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    apb_write(3, 8'h03);
    apb_write(0, 8'h99);
    apb_read(5, d);
    @(posedge PCLK); #1;
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 3'd7; PWDATA = 32'h55;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #2 PRESETn = 1;
    #1;
    vectors++;
    if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata got=%h exp=00000000", PRDATA); end
    @(posedge PCLK); #1;
    PSELx = 0; PENABLE = 0; PWRITE = 0;
    @(posedge PCLK); #1;
    PRESETn = 0;
    model_reset();
    test_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 0;
    vectors++;
    if (PRDATA !== 32'h0) begin errors++; $display("FAIL prdata_after_reset got=%h exp=00000000", PRDATA); end
    test_reset();
    test_ier_mask();
    test_dlab();
    test_loopback();
    test_fcr_ro();
    test_scratch();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/apb_user_registers.md
# apb_user_registers

16550-compatible UART user register file behind an AMBA APB slave port. It decodes a 3-bit word address into the eight classic 16550 byte registers, including DLAB-banked divisor latches. It provides a software-visible loopback holding register, so the register map can be exercised without a serial datapath. It sits between the APB fabric and the (future) UART core.

## Interface
- No parameters.
- PCLK  input  1  sole clock; all state updates on rising edge.
- PRESETn  input  1  asynchronous, active-high reset (asserted when 1); name retained from the codebase.
- PADDR  input  3  register index 0-7.
- PSELx  input  1  slave select.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  32  write data; only [7:0] used, [31:8] ignored (may be X/Z).
- PRDATA  output  32  read data, {24'b0, reg[7:0]}; registered.

## Operation
- DLAB = LCR[7].
- Addr 0, DLAB=0:
  - Write: THR/RBR holding byte <= data; sets DR.
  - Read: returns holding byte; clears DR.
- Addr 0, DLAB=1: DLL, RW.
- Addr 1, DLAB=0: IER; bits [3:0] writable, [7:4] read 0.
- Addr 1, DLAB=1: DLM, RW.
- Addr 2 write: FCR is write-only. Stores bit0 (FIFO enable) and bits [7:6] (trigger level). Bits 1-2 are self-clearing (no state); bits 3-5 are ignored.
- Addr 2 read: IIR = {FCR[0],FCR[0],2'b00, id[3:0]}.
  - id = 4'b0100 when IER[0] & DR.
  - Otherwise id = 4'b0001 (no interrupt).
- Addr 3: LCR, full 8-bit RW.
- Addr 4: MCR; bits [4:0] RW, [7:5] read 0.
- Addr 5: LSR, read-only = {1'b0, 1'b1, 1'b1, 4'b0000, DR}. Writes ignored.
- Addr 6: MSR, read-only 8'h00. Writes ignored.
- Addr 7: SCR, 8-bit RW (see Configuration).
- Reset values:
  - RBR/THR, DLL, DLM, IER, FCR, LCR, MCR, SCR, DR = 0.
  - Hence IIR = 8'h01 and LSR = 8'h60 after reset.
- Reset asserted mid-transfer aborts the transfer. All state, including PRDATA, returns to reset values immediately.

## Timing
- No PREADY; every transfer is zero-wait: one setup cycle (PSELx=1, PENABLE=0), then one access cycle (PSELx=1, PENABLE=1).
- Write commit: the rising edge where PSELx & PENABLE & PWRITE. The register is updated and visible to a read setup in the next cycle.
- Read capture: the rising edge where PSELx & ~PENABLE & ~PWRITE. PRDATA is loaded at that edge, so it is valid for the whole access phase.
- Read holds: PRDATA keeps its value until the next read setup edge or reset. Writes do not change PRDATA.
- DR clear on RBR read occurs at the access-phase edge (PSELx & PENABLE & ~PWRITE, addr 0, DLAB=0).
- DR set on THR write occurs at the write commit edge.
- DLAB banking uses the LCR value at the decoding edge. A read in the cycle after an LCR write sees the new bank.
- Transactions with PSELx=0 have no effect. PENABLE without PSELx is ignored.

## Configuration
- SCRATCH_REG_EN
  - Defined: addr 7 is the 8-bit RW scratch register SCR.
  - Undefined: SCR is not implemented; addr 7 reads 8'h00 and writes are ignored.

## Test plan
- Reset defaults: release reset, read addr 0-7 -> 00,00,01,00,00,60,00,00.
- IER masking: write 8'hFF to addr 1 (DLAB=0), then read addr 1 -> PRDATA = 32'h0000000F.
- DLAB banking:
  - Write 8'hAA to LCR (addr 3); read addr 3 -> 32'h000000AA.
  - Write 8'hFF to addr 1; read addr 1 -> 32'h000000FF (DLM).
  - Write LCR=8'h03; read addr 1 -> 32'h0000000F (IER untouched).
- Loopback and IIR:
  - With IER=8'h01 and DLAB=0, write 8'h5A to addr 0.
  - Read LSR -> 8'h61; read IIR -> 8'h04.
  - Read addr 0 -> 8'h5A.
  - Read LSR -> 8'h60; read IIR -> 8'h01.
- FCR/IIR and read-only regs:
  - Write 8'hC1 to addr 2; read addr 2 -> 8'hC1.
  - Write 8'hFF to addr 5 and 6; reads are unchanged (60/00).
- Scratch and async reset:
  - With SCRATCH_REG_EN, write 8'h3C to addr 7 -> read 8'h3C. Without it, the same sequence reads 8'h00.
  - Assert reset during an access phase -> all reads return reset defaults and PRDATA = 0 immediately.
